spi_cmd_rx: RTL and testbench

SPI_CMD_RX -- requirements
Module: spi_cmd_rx

---
 rtl/spi_cmd_rx.sv | 248 ++++++++++++++++++++++++
 tb/tb_spi_cmd_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_rx.sv
// SPI command receiver: synchronizes a mode-0 SPI slave port into the clk domain,
// collects a 19-bit {sel, a, b} frame and presents it to the ALU stage.
module spi_cmd_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic signed [7:0] a,
   output logic signed [7:0] b,
   output logic [2:0]        sel,
   output logic              aluop_st,
   output logic              cmd_valid,
   output logic              frame_err
);

   localparam logic [4:0] CNT_FRAME = 5'(FRAME_BITS);
   localparam logic [4:0] CNT_SAT   = 5'(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES:0]   settle_q;
   logic                   sclk_prev_q;
   logic                   cs_prev_q;
   logic                   armed_q;
   logic                   armed_d;

   logic                   sclk_cur_s;
   logic                   cs_cur_s;
   logic                   mosi_cur_s;
   logic                   sclk_rise_s;
   logic                   cs_fall_s;
   logic                   cs_rise_s;

   state_t                 state_q;
   state_t                 state_d;
   logic [FRAME_BITS-1:0]  sr_q;
   logic [FRAME_BITS-1:0]  sr_d;
   logic [4:0]             cnt_q;
   logic [4:0]             cnt_d;
   logic [4:0]             cnt_inc_s;
   logic [4:0]             cnt_next_s;

   logic signed [7:0]      a_q;
   logic signed [7:0]      a_d;
   logic signed [7:0]      b_q;
   logic signed [7:0]      b_d;
   logic [2:0]             sel_q;
   logic [2:0]             sel_d;
   logic                   aluop_q;
   logic                   aluop_d;
   logic                   cmd_valid_q;
   logic                   cmd_valid_d;
   logic                   frame_err_q;
   logic                   frame_err_d;

   // Synchronizer chains and the extra registered copy used for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         settle_q    <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         armed_q     <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
         sclk_prev_q <= sclk_cur_s;
         cs_prev_q   <= cs_cur_s;
         armed_q     <= armed_d;
      end
   end

   assign sclk_cur_s = sclk_sync_q[SYNC_STAGES-1];
   assign cs_cur_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_cur_s = mosi_sync_q[SYNC_STAGES-1];

   // A frame may only start after a genuine cs_n high has been seen since reset,
   // so a chip select already low at reset release is never taken as a start.
   always_comb begin
      armed_d = armed_q;
      if (settle_q[SYNC_STAGES] && cs_cur_s) begin
         armed_d = 1'b1;
      end else begin
         armed_d = armed_q;
      end
   end

   assign sclk_rise_s = sclk_cur_s & ~sclk_prev_q;
   assign cs_fall_s   = armed_q & cs_prev_q & ~cs_cur_s;
   assign cs_rise_s   = cs_cur_s & ~cs_prev_q;

   // Bit count including a bit arriving this cycle, so a coincident cs_n rise sees it.
   assign cnt_inc_s  = (cnt_q == CNT_SAT) ? CNT_SAT : (cnt_q + 5'd1);
   assign cnt_next_s = sclk_rise_s ? cnt_inc_s : cnt_q;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall_s) begin
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cs_rise_s) begin
               if (cnt_next_s == CNT_FRAME) begin
                  state_d = ST_COMMIT;
               end else begin
                  state_d = ST_ERROR;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         ST_ERROR:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Shift register and bit counter next-state.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall_s) begin
               sr_d  = '0;
               cnt_d = 5'd0;
            end else begin
               sr_d  = sr_q;
               cnt_d = cnt_q;
            end
         end
         ST_SHIFT: begin
            if (sclk_rise_s) begin
               sr_d  = {sr_q[FRAME_BITS-2:0], mosi_cur_s};
               cnt_d = cnt_inc_s;
            end else begin
               sr_d  = sr_q;
               cnt_d = cnt_q;
            end
         end
         default: begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
         end
      endcase
   end

   // Shift register and bit counter storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= 5'd0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   // FSM output logic feeding the registered outputs.
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      sel_d       = sel_q;
      aluop_d     = aluop_q;
      cmd_valid_d = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall_s) begin
               aluop_d = 1'b0;
            end else begin
               aluop_d = aluop_q;
            end
         end
         ST_COMMIT: begin
            sel_d       = sr_q[FRAME_BITS-1 -: 3];
            a_d         = sr_q[15:8];
            b_d         = sr_q[7:0];
            aluop_d     = 1'b1;
            cmd_valid_d = 1'b1;
         end
         ST_ERROR: begin
            frame_err_d = 1'b1;
         end
         default: begin
            aluop_d = aluop_q;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= 8'sd0;
         b_q         <= 8'sd0;
         sel_q       <= 3'd0;
         aluop_q     <= 1'b0;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         aluop_q     <= aluop_d;
         cmd_valid_q <= cmd_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign sel       = sel_q;
   assign aluop_st  = aluop_q;
   assign cmd_valid = cmd_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Bench for spi_cmd_rx: table of directed frames, reset/idle corner sequences,
// then random frames judged by a frame-level reference model.
module tb_spi_cmd_rx;

   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic cs_n = 1'b1;
   logic mosi = 1'b0;
   logic signed [7:0] a;
   logic signed [7:0] b;
   logic [2:0] sel;
   logic aluop_st;
   logic cmd_valid;
   logic frame_err;
   logic [7:0] a_u;
   logic [7:0] b_u;

   int n_chk = 0;
   int n_pass = 0;
   int cv_total = 0;
   int fe_total = 0;
   int both_total = 0;

   // reference model: last committed command as seen by the ALU
   logic [2:0] m_sel = 3'd0;
   logic [7:0] m_a = 8'd0;
   logic [7:0] m_b = 8'd0;
   logic       m_aluop = 1'b0;

   typedef struct {
      int          nbits;
      logic [31:0] bits;
      bit          tight;
      bit          exp_ok;
      logic [2:0]  e_sel;
      logic [7:0]  e_a;
      logic [7:0]  e_b;
   } vec_t;

   vec_t tbl [6];

   spi_cmd_rx #(.SYNC_STAGES(SYNC), .FRAME_BITS(19)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .a(a), .b(b), .sel(sel), .aluop_st(aluop_st),
      .cmd_valid(cmd_valid), .frame_err(frame_err)
   );

   assign a_u = a;
   assign b_u = b;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cmd_valid) cv_total++;
      if (frame_err) fe_total++;
      if (cmd_valid && frame_err) both_total++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_sel"},   32'(sel),      32'(m_sel));
      chk({tag, "_a"},     32'(a_u),      32'(m_a));
      chk({tag, "_b"},     32'(b_u),      32'(m_b));
      chk({tag, "_aluop"}, 32'(aluop_st), 32'(m_aluop));
   endtask

   task automatic send_frame(input int n, input logic [31:0] bits, input bit tight,
                             input bit exp_ok, input logic [2:0] e_sel,
                             input logic [7:0] e_a, input logic [7:0] e_b);
      int cv0;
      int fe0;
      cv0 = cv_total;
      fe0 = fe_total;
      @(negedge clk);
      cs_n = 1'b0;
      wait_clk(SYNC);
      chk("aluop_hold_at_fall", 32'(aluop_st), 32'(m_aluop));
      wait_clk(1);
      chk("aluop_drop_after_fall", 32'(aluop_st), 32'd0);
      m_aluop = 1'b0;
      wait_clk(4);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = bits[i];
         sclk = 1'b0;
         wait_clk(4);
         sclk = 1'b1;
         if (!(tight && i == 0)) wait_clk(4);
      end
      if (tight) begin
         cs_n = 1'b1;
      end else begin
         sclk = 1'b0;
         wait_clk(4);
         cs_n = 1'b1;
      end
      wait_clk(SYNC + 1);
      chk("no_early_pulse", 32'(cmd_valid | frame_err | aluop_st), 32'd0);
      wait_clk(1);
      chk("cmd_valid_pulse", 32'(cmd_valid), 32'(exp_ok));
      chk("frame_err_pulse", 32'(frame_err), 32'(!exp_ok));
      if (exp_ok) begin
         m_sel = e_sel;
         m_a = e_a;
         m_b = e_b;
         m_aluop = 1'b1;
      end
      wait_clk(4);
      sclk = 1'b0;
      chk("cmd_valid_count", 32'(cv_total - cv0), 32'(exp_ok));
      chk("frame_err_count", 32'(fe_total - fe0), 32'(!exp_ok));
      check_model("frame");
   endtask

   initial begin
      int cv0;
      int fe0;
      int n;
      logic [31:0] bits;
      int lens [6];
      lens = '{17, 18, 19, 19, 19, 20};

      tbl[0] = '{19, {13'd0, 3'd0, 8'h14, 8'h0A}, 1'b0, 1'b1, 3'd0, 8'h14, 8'h0A};
      tbl[1] = '{18, 32'h0002_A5A5,              1'b0, 1'b0, 3'd0, 8'h14, 8'h0A};
      tbl[2] = '{20, 32'h000F_1234,              1'b0, 1'b0, 3'd0, 8'h14, 8'h0A};
      tbl[3] = '{19, {13'd0, 3'd1, 8'hFB, 8'h03}, 1'b0, 1'b1, 3'd1, 8'hFB, 8'h03};
      tbl[4] = '{19, {13'd0, 3'd5, 8'h7F, 8'h80}, 1'b0, 1'b1, 3'd5, 8'h7F, 8'h80};
      tbl[5] = '{19, {13'd0, 3'd6, 8'hA5, 8'h01}, 1'b1, 1'b1, 3'd6, 8'hA5, 8'h01};

      wait_clk(3);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_a", 32'(a_u), 32'd0);
      chk("rst_b", 32'(b_u), 32'd0);
      chk("rst_pulses", 32'(aluop_st | cmd_valid | frame_err), 32'd0);
      rst_n = 1'b1;
      wait_clk(10);

      for (int i = 0; i < 6; i++) begin
         send_frame(tbl[i].nbits, tbl[i].bits, tbl[i].tight, tbl[i].exp_ok,
                    tbl[i].e_sel, tbl[i].e_a, tbl[i].e_b);
         chk("tbl_sel", 32'(sel), 32'(tbl[i].e_sel));
         chk("tbl_a", 32'(a_u), 32'(tbl[i].e_a));
         chk("tbl_b", 32'(b_u), 32'(tbl[i].e_b));
         chk("tbl_aluop", 32'(aluop_st), 32'(tbl[i].exp_ok));
      end

      // sclk activity with chip select idle must be invisible
      cv0 = cv_total;
      fe0 = fe_total;
      for (int i = 0; i < 8; i++) begin
         mosi = 1'($urandom_range(0, 1));
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
         wait_clk(4);
      end
      chk("idle_pulses", 32'((cv_total - cv0) + (fe_total - fe0)), 32'd0);
      check_model("idle");

      // reset in the middle of a frame discards it
      cv0 = cv_total;
      fe0 = fe_total;
      cs_n = 1'b0;
      wait_clk(8);
      for (int i = 0; i < 10; i++) begin
         mosi = 1'($urandom_range(0, 1));
         sclk = 1'b0;
         wait_clk(4);
         sclk = 1'b1;
         wait_clk(4);
      end
      rst_n = 1'b0;
      #1;
      m_sel = 3'd0;
      m_a = 8'd0;
      m_b = 8'd0;
      m_aluop = 1'b0;
      check_model("in_reset");
      chk("in_reset_pulses", 32'(cmd_valid | frame_err), 32'd0);
      wait_clk(3);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         mosi = 1'($urandom_range(0, 1));
         sclk = 1'b0;
         wait_clk(4);
         sclk = 1'b1;
         wait_clk(4);
      end
      sclk = 1'b0;
      wait_clk(4);
      cs_n = 1'b1;
      wait_clk(10);
      chk("post_reset_cmd_valid", 32'(cv_total - cv0), 32'd0);
      chk("post_reset_frame_err", 32'(fe_total - fe0), 32'd0);
      check_model("post_reset");

      // random frames judged by the frame-level model
      for (int k = 0; k < 12; k++) begin
         n = lens[$urandom_range(0, 5)];
         bits = $urandom & ((32'd1 << n) - 32'd1);
         send_frame(n, bits, 1'($urandom_range(0, 1)), n == 19,
                    bits[18:16], bits[15:8], bits[7:0]);
      end

      chk("never_both_pulses", 32'(both_total), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
